// File: rtl/counter_pkg.sv
// Shared types and constants for the push-button counter controller:
// the operating-mode enumeration and the bit positions of the button pulse bus.
package counter_pkg;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } mode_e;

  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_CLR  = 2;
  localparam int BTN_MODE = 3;
  localparam int BTN_W    = 4;

endpackage

// File: rtl/tick_generator.sv
// Rate tick generator for the auto-count modes. Counts 0..TICK_CNT_MAX-1
// while enabled and asserts tick combinationally in the terminal cycle, so
// the consumer steps on the same edge where the counter folds back to 0.
// The counter is held at 0 while disabled, and restart forces it back to 0.
module tick_generator #(
  parameter int TICK_CNT_MAX = 125000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (TICK_CNT_MAX > 2) ? $clog2(TICK_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT_MAX - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == CNT_LAST);

  // A restart in the same cycle as the terminal count suppresses the step.
  assign tick = enable && !restart && at_last;

  // Rate counter: cleared on restart or while disabled, wraps at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !enable) begin
      cnt <= '0;
    end else if (at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pushbutton_counter_ctrl.sv
// Push-button counter controller. Consumes one-cycle button pulses
// (inc, dec, clr, mode) and maintains a registered counter value with a
// MANUAL / AUTO_UP / AUTO_DOWN mode machine. Auto modes step the counter on
// a rate tick from tick_generator. wrap pulses for one cycle whenever the
// counter wraps past its range.
// Build option: define COUNTER_SATURATE_EN to make the counter saturate at
// its limits instead of wrapping; wrap then flags each attempted step past
// a limit.
module pushbutton_counter_ctrl
  import counter_pkg::*;
#(
  parameter int COUNT_WIDTH  = 8,
  parameter int TICK_CNT_MAX = 125000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BTN_W-1:0]       btn_pulse,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [1:0]             mode,
  output logic                   wrap
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MIN = '0;

  // Returns {limit_hit, next_value} for an upward step.
  function automatic logic [COUNT_WIDTH:0] step_up_fn(input logic [COUNT_WIDTH-1:0] v);
    logic lim;
    lim = (v == COUNT_MAX);
`ifdef COUNTER_SATURATE_EN
    return lim ? {1'b1, v} : {1'b0, v + 1'b1};
`else
    return {lim, v + 1'b1};
`endif
  endfunction

  // Returns {limit_hit, next_value} for a downward step.
  function automatic logic [COUNT_WIDTH:0] step_down_fn(input logic [COUNT_WIDTH-1:0] v);
    logic lim;
    lim = (v == COUNT_MIN);
`ifdef COUNTER_SATURATE_EN
    return lim ? {1'b1, v} : {1'b0, v - 1'b1};
`else
    return {lim, v - 1'b1};
`endif
  endfunction

  mode_e                  state;
  mode_e                  state_next;
  logic                   mode_change;
  logic                   tick;
  logic                   tick_en;
  logic                   tick_restart;
  logic                   inc_p;
  logic                   dec_p;
  logic                   clr_p;
  logic                   mode_p;
  logic                   step_up;
  logic                   step_down;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   wrap_next;

  assign inc_p  = btn_pulse[BTN_INC];
  assign dec_p  = btn_pulse[BTN_DEC];
  assign clr_p  = btn_pulse[BTN_CLR];
  assign mode_p = btn_pulse[BTN_MODE];

  assign mode = state;

  // Any transition of the mode machine (including recovery from an illegal
  // encoding) and any clear restart the rate counter from 0.
  assign mode_change  = (state_next != state);
  assign tick_en      = (state == AUTO_UP) || (state == AUTO_DOWN);
  assign tick_restart = clr_p || mode_change;

  tick_generator #(
    .TICK_CNT_MAX(TICK_CNT_MAX)
  ) u_tick_generator (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tick_en),
    .restart(tick_restart),
    .tick   (tick)
  );

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MANUAL;
    end else begin
      state <= state_next;
    end
  end

  // Mode next-state: each mode pulse advances MANUAL -> AUTO_UP -> AUTO_DOWN -> MANUAL.
  always_comb begin
    state_next = state;
    case (state)
      MANUAL:    if (mode_p) state_next = AUTO_UP;
      AUTO_UP:   if (mode_p) state_next = AUTO_DOWN;
      AUTO_DOWN: if (mode_p) state_next = MANUAL;
      default:   state_next = MANUAL;
    endcase
  end

  // Count next-value: manual pulses or rate ticks select a step, clear wins.
  always_comb begin
    step_up    = 1'b0;
    step_down  = 1'b0;
    count_next = count;
    wrap_next  = 1'b0;
    case (state)
      MANUAL: begin
        step_up   = inc_p && !dec_p;
        step_down = dec_p && !inc_p;
      end
      AUTO_UP:   step_up   = tick;
      AUTO_DOWN: step_down = tick;
      default: begin
        step_up   = 1'b0;
        step_down = 1'b0;
      end
    endcase
    if (clr_p) begin
      count_next = '0;
    end else if (step_up) begin
      {wrap_next, count_next} = step_up_fn(count);
    end else if (step_down) begin
      {wrap_next, count_next} = step_down_fn(count);
    end
  end

  // Registered count and wrap outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_pushbutton_counter_ctrl.sv
// Directed testbench for pushbutton_counter_ctrl with COUNT_WIDTH=8 and
// TICK_CNT_MAX=4. Expected values are hand-computed; the saturating build is
// covered by the COUNTER_SATURATE_EN branches.
module tb_pushbutton_counter_ctrl;

  localparam int CW  = 8;
  localparam int TCM = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    btn_pulse;
  logic [CW-1:0] count;
  logic [1:0]    mode;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  pushbutton_counter_ctrl #(
    .COUNT_WIDTH (CW),
    .TICK_CNT_MAX(TCM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_pulse(btn_pulse),
    .count    (count),
    .mode     (mode),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive btn for one clock edge; returns 1 time unit after that edge.
  task automatic apply(input logic [3:0] b);
    btn_pulse = b;
    @(posedge clk);
    #1;
    btn_pulse = 4'd0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    btn_pulse = 4'd0;
    #23;
    check("reset_count", count, 0);
    check("reset_mode",  mode,  0);
    check("reset_wrap",  wrap,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Manual inc/dec
    apply(4'b0001); check("inc1", count, 1);
    apply(4'b0001); check("inc2", count, 2);
    apply(4'b0001); check("inc3", count, 3);
    apply(4'b0010); check("dec1", count, 2);
    check("manual_mode", mode, 0);

    // Back-to-back inc pulses on consecutive cycles
    btn_pulse = 4'b0001;
    @(posedge clk); #1;
    check("b2b_first", count, 3);
    @(posedge clk); #1;
    btn_pulse = 4'd0;
    check("b2b_second", count, 4);

    // Same-cycle inc+dec, then clr+inc
    apply(4'b0011); check("inc_dec_same", count, 4);
    apply(4'b0101); check("clr_inc_same", count, 0);

    // Boundary behaviour at 0 and 2^CW-1
    apply(4'b0010);
`ifdef COUNTER_SATURATE_EN
    check("dec_at_zero", count, 0);
`else
    check("dec_at_zero", count, 255);
`endif
    check("dec_at_zero_wrap", wrap, 1);
    wait_cycles(1);
    check("wrap_one_cycle", wrap, 0);
`ifdef COUNTER_SATURATE_EN
    for (int i = 0; i < 255; i++) apply(4'b0001);
`endif
    check("at_max", count, 255);
    check("at_max_nowrap", wrap, 0);
    apply(4'b0001);
`ifdef COUNTER_SATURATE_EN
    check("inc_at_max", count, 255);
`else
    check("inc_at_max", count, 0);
`endif
    check("inc_at_max_wrap", wrap, 1);
    wait_cycles(1);
    check("inc_at_max_wrap_end", wrap, 0);
    apply(4'b0100); check("clr", count, 0);

    // AUTO_UP: steps 4, 8, 12 cycles after the mode edge
    apply(4'b1000);
    check("auto_up_mode", mode, 1);
    check("auto_up_start", count, 0);
    wait_cycles(3); check("auto_up_e3",  count, 0);
    wait_cycles(1); check("auto_up_e4",  count, 1);
    wait_cycles(4); check("auto_up_e8",  count, 2);
    wait_cycles(4); check("auto_up_e12", count, 3);
    apply(4'b0001); check("auto_inc_ignored", count, 3);
    wait_cycles(1);
    // tick counter now at 2 of 4; clear restarts it
    apply(4'b0100); check("auto_clr", count, 0);
    check("auto_clr_mode", mode, 1);
    wait_cycles(3); check("after_clr_e3", count, 0);
    wait_cycles(1); check("after_clr_e4", count, 1);

    // AUTO_DOWN: decrements 4 cycles after mode edge, wraps/saturates at 0
    apply(4'b1000);
    check("auto_down_mode", mode, 2);
    check("auto_down_start", count, 1);
    wait_cycles(3); check("auto_down_e3", count, 1);
    wait_cycles(1); check("auto_down_e4", count, 0);
    wait_cycles(4);
`ifdef COUNTER_SATURATE_EN
    check("auto_down_e8", count, 0);
`else
    check("auto_down_e8", count, 255);
`endif
    check("auto_down_wrap", wrap, 1);
    wait_cycles(1); check("auto_down_wrap_end", wrap, 0);

    // Mode cycles back to MANUAL; clr+mode both take effect
    apply(4'b1000); check("mode_to_manual", mode, 0);
    apply(4'b1100);
    check("clr_mode_mode",  mode,  1);
    check("clr_mode_count", count, 0);
    apply(4'b1000); check("mode_to_down2", mode, 2);
    apply(4'b1000); check("mode_to_manual2", mode, 0);
    for (int i = 0; i < 5; i++) apply(4'b0001);
    check("count_five", count, 5);
    apply(4'b1000);
    apply(4'b1000);
    check("down_five_mode",  mode,  2);
    check("down_five_count", count, 5);
    wait_cycles(2);
    check("down_five_hold", count, 5);

    // Asynchronous reset mid-cycle in AUTO_DOWN
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_mode",  mode,  0);
    check("async_rst_wrap",  wrap,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_count", count, 0);
    apply(4'b0001); check("post_rst_inc", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
